lfsr_gen: RTL and testbench

Parametrised pseudo-random generator, the next generation of the team's 8-bit LFSR.
- Configurable width and tap masks; Fibonacci or Galois form, selected at run time.
- Protects against an all-zero seed.
- Stalls through a valid/ready output handshake.
- Measures and reports the sequence period.
- Feeds test-pattern generators and scramblers in the shift/ datapath.

---
 rtl/lfsr_gen.sv | 154 +++++++++++++++
 tb/tb_lfsr_gen.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_gen.sv
// Parametrised LFSR pattern generator: Fibonacci or Galois form chosen at load,
// zero-seed substitution, valid/ready stall and sequence-period measurement.
module lfsr_gen #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] FTAPS    = WIDTH'(8'h1D),
    parameter logic [WIDTH-1:0] GTAPS    = WIDTH'(8'hB8),
    parameter logic [WIDTH-1:0] ZERO_SUB = WIDTH'(1'b1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] seed,
    input  logic             load,
    input  logic             stop,
    input  logic             mode,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld,
    input  logic             dout_rdy,
    output logic             bit_out,
    output logic [WIDTH-1:0] period,
    output logic             period_vld,
    output logic             zero_sub
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } fsm_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    fsm_t             r_fsm;
    fsm_t             w_fsm_nxt;
    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] r_seed;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_period;
    logic             r_period_vld;
    logic             r_zero_sub;
    logic             r_mode;

    logic             w_dout_vld;
    logic             w_seed_zero;
    logic [WIDTH-1:0] w_seed_eff;
    logic [WIDTH-1:0] w_fib_nxt;
    logic [WIDTH-1:0] w_gal_nxt;
    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_cnt_inc;
    logic             w_adv;
    logic             w_hit;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm <= S_IDLE;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    // FSM next-state logic: load beats stop
    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            S_IDLE: begin
                if (load) begin
                    w_fsm_nxt = S_RUN;
                end else begin
                    w_fsm_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (load) begin
                    w_fsm_nxt = S_RUN;
                end else if (stop) begin
                    w_fsm_nxt = S_IDLE;
                end else begin
                    w_fsm_nxt = S_RUN;
                end
            end
            default: w_fsm_nxt = S_IDLE;
        endcase
    end

    // FSM output decode, derived only from the state register
    always_comb begin
        w_dout_vld = 1'b0;
        case (r_fsm)
            S_IDLE:  w_dout_vld = 1'b0;
            S_RUN:   w_dout_vld = 1'b1;
            default: w_dout_vld = 1'b0;
        endcase
    end

    // Next-state candidates, seed substitution and advance/period-hit decode
    always_comb begin
        w_seed_zero = (seed == {WIDTH{1'b0}});
        if (w_seed_zero) begin
            w_seed_eff = ZERO_SUB;
        end else begin
            w_seed_eff = seed;
        end
        w_fib_nxt = {^(r_state & FTAPS), r_state[WIDTH-1:1]};
        w_gal_nxt = {1'b0, r_state[WIDTH-1:1]} ^ ({WIDTH{r_state[0]}} & GTAPS);
        if (r_mode) begin
            w_step = w_gal_nxt;
        end else begin
            w_step = w_fib_nxt;
        end
        w_cnt_inc = r_cnt + ONE;
        w_adv     = (r_fsm == S_RUN) && w_dout_vld && dout_rdy && !load && !stop;
        w_hit     = (w_step == r_seed);
    end

    // Datapath: load restarts the sequence, an accepted handshake advances it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= {WIDTH{1'b0}};
            r_seed       <= {WIDTH{1'b0}};
            r_cnt        <= {WIDTH{1'b0}};
            r_period     <= {WIDTH{1'b0}};
            r_period_vld <= 1'b0;
            r_zero_sub   <= 1'b0;
            r_mode       <= 1'b0;
        end else if (load) begin
            r_state      <= w_seed_eff;
            r_seed       <= w_seed_eff;
            r_zero_sub   <= w_seed_zero;
            r_mode       <= mode;
            r_cnt        <= {WIDTH{1'b0}};
            r_period_vld <= 1'b0;
        end else if (w_adv) begin
            r_state <= w_step;
            // Returning to the seed closes one period; the counter wraps naturally
            if (w_hit) begin
                r_period     <= w_cnt_inc;
                r_cnt        <= {WIDTH{1'b0}};
                r_period_vld <= 1'b1;
            end else begin
                r_cnt        <= w_cnt_inc;
                r_period_vld <= 1'b0;
            end
        end else begin
            r_period_vld <= 1'b0;
        end
    end

    assign dout       = r_state;
    assign dout_vld   = w_dout_vld;
    assign bit_out    = r_state[0];
    assign period     = r_period;
    assign period_vld = r_period_vld;
    assign zero_sub   = r_zero_sub;

endmodule

// File: tb/tb_lfsr_gen.sv
// Self-checking bench for lfsr_gen: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.
module tb_lfsr_gen;

    localparam logic [7:0] FT = 8'h1D;
    localparam logic [7:0] GT = 8'hB8;
    localparam logic [7:0] ZS = 8'h01;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] seed;
    logic       load, stop, mode, dout_rdy;
    logic [7:0] dout, period;
    logic       dout_vld, bit_out, period_vld, zero_sub;

    int checks   = 0;
    int failures = 0;

    // reference model state
    bit         m_run, m_mode, m_pvld, m_zs;
    logic [7:0] m_state, m_seed, m_period, m_cnt;

    lfsr_gen #(.WIDTH(8), .FTAPS(FT), .GTAPS(GT), .ZERO_SUB(ZS)) dut (
        .clk(clk), .rst_n(rst_n), .seed(seed), .load(load), .stop(stop),
        .mode(mode), .dout(dout), .dout_vld(dout_vld), .dout_rdy(dout_rdy),
        .bit_out(bit_out), .period(period), .period_vld(period_vld),
        .zero_sub(zero_sub)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s, input bit galois);
        logic [7:0] r;
        int ones;
        r = s >> 1;
        if (galois) begin
            if (s[0]) r = r ^ GT;
        end else begin
            ones = 0;
            for (int b = 0; b < 8; b++) if (FT[b] && s[b]) ones++;
            if (ones % 2 == 1) r[7] = 1'b1;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_run = 0; m_mode = 0; m_pvld = 0; m_zs = 0;
        m_state = 8'h00; m_seed = 8'h00; m_period = 8'h00; m_cnt = 8'h00;
    endtask

    // one clock: the model consumes the inputs held across this edge
    task automatic tick();
        logic [7:0] nx;
        m_pvld = 0;
        if (load) begin
            m_seed  = (seed == 8'h00) ? ZS : seed;
            m_state = m_seed;
            m_zs    = (seed == 8'h00);
            m_mode  = mode;
            m_cnt   = 8'h00;
            m_run   = 1;
        end else if (stop) begin
            m_run = 0;
        end else if (m_run && dout_rdy) begin
            nx    = lfsr_next(m_state, m_mode);
            m_cnt = m_cnt + 8'd1;
            if (nx == m_seed) begin
                m_period = m_cnt;
                m_cnt    = 8'h00;
                m_pvld   = 1;
            end
            m_state = nx;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        load = 0; stop = 0; mode = 0; dout_rdy = 0; seed = 8'h00;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle_inputs();
        model_reset();
        #12;
        checks++;
        if ({dout, dout_vld, bit_out, period, period_vld, zero_sub} !== 20'h0) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected 00000",
                     {dout, dout_vld, bit_out, period, period_vld, zero_sub});
        end
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fibonacci();
        logic [7:0] exp_seq [6] = '{8'h01, 8'h80, 8'h40, 8'h20, 8'h10, 8'h88};
        seed = 8'h01; mode = 0; dout_rdy = 1; load = 1;
        tick();
        load = 0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (dout !== exp_seq[i] || dout_vld !== 1'b1) begin
                failures++;
                $display("FAIL fib_seq[%0d]: got dout=%h vld=%b expected %h vld=1",
                         i, dout, dout_vld, exp_seq[i]);
            end
            tick();
        end
    endtask

    task automatic test_galois();
        logic [7:0] exp_seq [3] = '{8'h01, 8'hB8, 8'h5C};
        seed = 8'h01; mode = 1; dout_rdy = 1; load = 1;
        tick();
        load = 0; mode = 0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (dout !== exp_seq[i] || bit_out !== exp_seq[i][0]) begin
                failures++;
                $display("FAIL gal_seq[%0d]: got dout=%h bit=%b expected %h bit=%b",
                         i, dout, bit_out, exp_seq[i], exp_seq[i][0]);
            end
            tick();
        end
    endtask

    task automatic test_period();
        int pulses = 0;
        int at_step = -1;
        seed = 8'hA5; mode = 0; dout_rdy = 1; load = 1;
        tick();
        load = 0;
        for (int i = 1; i <= 260; i++) begin
            tick();
            if (period_vld) begin
                pulses++;
                at_step = i;
                checks++;
                if (period !== 8'd255 || dout !== 8'hA5) begin
                    failures++;
                    $display("FAIL period_value: got period=%0d dout=%h expected 255 A5",
                             period, dout);
                end
            end
        end
        checks++;
        if (pulses != 1 || at_step != 255) begin
            failures++;
            $display("FAIL period_pulse: got pulses=%0d at step %0d expected 1 at 255",
                     pulses, at_step);
        end
    endtask

    task automatic test_zero_seed();
        seed = 8'h00; mode = 0; dout_rdy = 1; load = 1;
        tick();
        load = 0;
        checks++;
        if (dout !== 8'h01 || zero_sub !== 1'b1) begin
            failures++;
            $display("FAIL zero_sub_load: got dout=%h zs=%b expected 01 1", dout, zero_sub);
        end
        tick();
        tick();
        checks++;
        if (zero_sub !== 1'b1) begin
            failures++;
            $display("FAIL zero_sub_sticky: got %b expected 1", zero_sub);
        end
        seed = 8'h33; load = 1;
        tick();
        load = 0;
        checks++;
        if (dout !== 8'h33 || zero_sub !== 1'b0) begin
            failures++;
            $display("FAIL zero_sub_clear: got dout=%h zs=%b expected 33 0", dout, zero_sub);
        end
    endtask

    task automatic test_back_to_back();
        logic       rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [7:0] prev;
        seed = 8'h5A; mode = 0; dout_rdy = 1; load = 1;
        tick();
        load = 0;
        for (int i = 0; i < 4; i++) begin
            dout_rdy = rdy_pat[i];
            prev = dout;
            tick();
            checks++;
            if (dout !== m_state || (rdy_pat[i] ? (dout === prev) : (dout !== prev))) begin
                failures++;
                $display("FAIL stall[%0d]: got dout=%h prev=%h rdy=%b expected %h",
                         i, dout, prev, rdy_pat[i], m_state);
            end
        end
        dout_rdy = 1; stop = 1;
        prev = dout;
        tick();
        stop = 0;
        tick();
        tick();
        checks++;
        if (dout_vld !== 1'b0 || dout !== prev) begin
            failures++;
            $display("FAIL stop_hold: got vld=%b dout=%h expected 0 %h", dout_vld, dout, prev);
        end
        seed = 8'hC3; load = 1; stop = 1;
        tick();
        load = 0; stop = 0;
        checks++;
        if (dout_vld !== 1'b1 || dout !== 8'hC3) begin
            failures++;
            $display("FAIL load_over_stop: got vld=%b dout=%h expected 1 C3", dout_vld, dout);
        end
    endtask

    task automatic test_async_reset();
        int pulses = 0;
        seed = 8'h00; mode = 1; dout_rdy = 1; load = 1;
        tick();
        load = 0;
        for (int i = 0; i < 7; i++) tick();
        #3;
        rst_n = 0;
        #1;
        model_reset();
        checks++;
        if ({dout, dout_vld, bit_out, period, period_vld, zero_sub} !== 20'h0) begin
            failures++;
            $display("FAIL async_reset: got %h expected 00000",
                     {dout, dout_vld, bit_out, period, period_vld, zero_sub});
        end
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (period_vld || dout_vld) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL idle_after_reset: got %0d active cycles expected 0", pulses);
        end
        seed = 8'h5B; mode = 1; load = 1;
        tick();
        load = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (period_vld) pulses++;
            checks++;
            if ({dout, dout_vld, bit_out, period, period_vld, zero_sub} !==
                {m_state, m_run, m_state[0], m_period, m_pvld, m_zs}) begin
                failures++;
                $display("FAIL galois_run[%0d]: got %h expected %h", i,
                         {dout, dout_vld, bit_out, period, period_vld, zero_sub},
                         {m_state, m_run, m_state[0], m_period, m_pvld, m_zs});
            end
        end
        checks++;
        if (pulses < 1) begin
            failures++;
            $display("FAIL galois_period_seen: got %0d pulses expected at least 1", pulses);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            load     = ($urandom_range(0, 199) == 0);
            stop     = ($urandom_range(0, 149) == 0);
            dout_rdy = ($urandom_range(0, 3) != 0);
            mode     = $urandom_range(0, 1);
            seed     = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            tick();
            checks++;
            if ({dout, dout_vld, bit_out, period, period_vld, zero_sub} !==
                {m_state, m_run, m_state[0], m_period, m_pvld, m_zs}) begin
                failures++;
                $display("FAIL random[%0d]: got %h expected %h", i,
                         {dout, dout_vld, bit_out, period, period_vld, zero_sub},
                         {m_state, m_run, m_state[0], m_period, m_pvld, m_zs});
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_fibonacci();
        test_galois();
        test_period();
        test_zero_seed();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
